// File: rtl/pio_button_debounce_irq.sv
// Avalon-MM push-button input port.
// Each input bit passes through a synchroniser and a debouncer with a runtime
// threshold. The port captures selected edges with write-1-to-clear, counts
// event cycles in a saturating counter, and raises a maskable level irq.
module pio_button_debounce_irq #(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               CNT_W           = 16,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] INIT_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] THRESH_RST = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // Register word addresses
  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_RAW    = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_EDGE   = 3'd3;
  localparam logic [2:0] A_RISE   = 3'd4;
  localparam logic [2:0] A_FALL   = 3'd5;
  localparam logic [2:0] A_EVCNT  = 3'd6;
  localparam logic [2:0] A_THRESH = 3'd7;

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;

  logic [WIDTH-1:0] stable_reg;
  logic [WIDTH-1:0] stable_next;
  logic [CNT_W-1:0] cnt_reg  [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] event_vec;

  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] edge_cap_reg;
  logic [WIDTH-1:0] edge_cap_next;
  logic [WIDTH-1:0] rise_en_reg;
  logic [WIDTH-1:0] fall_en_reg;
  logic [CNT_W-1:0] event_cnt_reg;
  logic [CNT_W-1:0] event_cnt_next;
  logic [CNT_W-1:0] thresh_reg;
  logic [31:0]      rd_next;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [CNT_W-1:0] wr_cnt;
  logic             unused_wdata;

  assign wr_en   = chipselect && !write_n;
  assign wr_bits = writedata[WIDTH-1:0];
  assign wr_cnt  = writedata[CNT_W-1:0];
  // Upper writedata bits are intentionally ignored for narrow registers.
  assign unused_wdata = ^writedata;

  // Synchroniser chain; idles at INIT_LEVEL so reset release makes no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= INIT_LEVEL;
      end
    end else begin
      sync_reg[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // Per-bit debouncer. A bit flips once it has disagreed with the stable
  // value for THRESH+1 consecutive cycles; any agreement restarts the count.
  // The >= compare lets a lowered threshold take effect at once.
  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic mismatch;
    assign mismatch        = sync_out[gi] ^ stable_reg[gi];
    assign flip[gi]        = mismatch && (cnt_reg[gi] >= thresh_reg);
    assign cnt_next[gi]    = (mismatch && !flip[gi]) ? cnt_reg[gi] + 1'b1 : '0;
    assign stable_next[gi] = flip[gi] ? sync_out[gi] : stable_reg[gi];
    assign event_vec[gi]   = flip[gi] && (sync_out[gi] ? rise_en_reg[gi] : fall_en_reg[gi]);
  end

  // A new event outranks a simultaneous write-1-to-clear on the same bit.
  assign edge_cap_next = (edge_cap_reg & ~((wr_en && address == A_EDGE) ? wr_bits : '0))
                         | event_vec;

  // Event counter: one count per cycle with any event; a clear that
  // coincides with an event leaves the count at one.
  always_comb begin
    event_cnt_next = event_cnt_reg;
    if (wr_en && address == A_EVCNT) begin
      event_cnt_next = '0;
    end
    if ((|event_vec) && (event_cnt_next != CNT_MAX)) begin
      event_cnt_next = event_cnt_next + 1'b1;
    end
  end

  // Read mux; reads never change state.
  always_comb begin
    rd_next = '0;
    case (address)
      A_DATA:   rd_next[WIDTH-1:0] = stable_reg;
      A_RAW:    rd_next[WIDTH-1:0] = sync_out;
      A_MASK:   rd_next[WIDTH-1:0] = irq_mask_reg;
      A_EDGE:   rd_next[WIDTH-1:0] = edge_cap_reg;
      A_RISE:   rd_next[WIDTH-1:0] = rise_en_reg;
      A_FALL:   rd_next[WIDTH-1:0] = fall_en_reg;
      A_EVCNT:  rd_next[CNT_W-1:0] = event_cnt_reg;
      A_THRESH: rd_next[CNT_W-1:0] = thresh_reg;
      default:  rd_next = '0;
    endcase
  end

  // Debounce state: stable level and per-bit mismatch counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_reg <= INIT_LEVEL;
      for (int b = 0; b < WIDTH; b++) begin
        cnt_reg[b] <= '0;
      end
    end else begin
      stable_reg <= stable_next;
      for (int b = 0; b < WIDTH; b++) begin
        cnt_reg[b] <= cnt_next[b];
      end
    end
  end

  // Control/status registers, capture, counter and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_reg  <= '0;
      edge_cap_reg  <= '0;
      rise_en_reg   <= '0;
      fall_en_reg   <= '1;
      event_cnt_reg <= '0;
      thresh_reg    <= THRESH_RST;
      readdata      <= '0;
    end else begin
      edge_cap_reg  <= edge_cap_next;
      event_cnt_reg <= event_cnt_next;
      readdata      <= rd_next;
      if (wr_en) begin
        case (address)
          A_MASK:   irq_mask_reg <= wr_bits;
          A_RISE:   rise_en_reg  <= wr_bits;
          A_FALL:   fall_en_reg  <= wr_bits;
          A_THRESH: thresh_reg   <= wr_cnt;
          default:  ;
        endcase
      end
    end
  end

  assign irq = |(edge_cap_reg & irq_mask_reg);

endmodule

// File: tb/tb_pio_button_debounce_irq.sv
// Bench for pio_button_debounce_irq. Two instances share one stimulus: a
// default build (CNT_W=16) and a narrow one (CNT_W=2) for counter saturation.
// A timestamp-based model predicts readdata/irq of both on every cycle, and
// directed reads pin the model with hand-computed literals.
module tb_pio_button_debounce_irq;

  localparam int         SYNC = 2;
  localparam logic [3:0] INIT = 4'hF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata_a, readdata_b;
  logic        irq_a, irq_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  always #5 clk = ~clk;

  pio_button_debounce_irq #(
    .WIDTH(4), .SYNC_STAGES(SYNC), .CNT_W(16), .DEBOUNCE_CYCLES(50000), .INIT_LEVEL(4'hF)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_a), .irq(irq_a)
  );

  pio_button_debounce_irq #(
    .WIDTH(4), .SYNC_STAGES(SYNC), .CNT_W(2), .DEBOUNCE_CYCLES(3), .INIT_LEVEL(4'hF)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_b), .irq(irq_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  m_stable [2];
  logic [3:0]  m_mask   [2];
  logic [3:0]  m_ec     [2];
  logic [3:0]  m_rise   [2];
  logic [3:0]  m_fall   [2];
  int          m_cnt    [2];
  int          m_thr    [2];
  int          m_since  [2][4];  // edge index where the current disagreement began, -1 if none
  logic [31:0] m_rd     [2];
  logic [3:0]  in_hist  [16];
  int          edge_idx;

  function automatic int cnt_max(input int k);
    return (k == 0) ? 65535 : 3;
  endfunction

  function automatic logic [3:0] hist(input int k);
    if (k < 0) return INIT;
    return in_hist[k % 16];
  endfunction

  task automatic m_reset();
    edge_idx = 0;
    for (int k = 0; k < 2; k++) begin
      m_stable[k] = INIT; m_mask[k] = 4'h0; m_ec[k] = 4'h0;
      m_rise[k] = 4'h0; m_fall[k] = 4'hF; m_cnt[k] = 0;
      m_thr[k] = (k == 0) ? 50000 : 3; m_rd[k] = 32'h0;
      for (int b = 0; b < 4; b++) m_since[k][b] = -1;
    end
  endtask

  task automatic m_step();
    logic [3:0] sv;
    logic [3:0] ev;
    bit         wr;
    sv = hist(edge_idx - SYNC);   // synchronised value seen by the debouncer at this edge
    wr = chipselect && !write_n;
    for (int k = 0; k < 2; k++) begin
      case (address)
        3'd0: m_rd[k] = {28'h0, m_stable[k]};
        3'd1: m_rd[k] = {28'h0, sv};
        3'd2: m_rd[k] = {28'h0, m_mask[k]};
        3'd3: m_rd[k] = {28'h0, m_ec[k]};
        3'd4: m_rd[k] = {28'h0, m_rise[k]};
        3'd5: m_rd[k] = {28'h0, m_fall[k]};
        3'd6: m_rd[k] = 32'(m_cnt[k]);
        default: m_rd[k] = 32'(m_thr[k]);
      endcase
      ev = 4'h0;
      for (int b = 0; b < 4; b++) begin
        if (sv[b] != m_stable[k][b]) begin
          if (m_since[k][b] < 0) m_since[k][b] = edge_idx;
          if (edge_idx - m_since[k][b] >= m_thr[k]) begin
            m_stable[k][b] = sv[b];
            m_since[k][b]  = -1;
            if (sv[b] ? m_rise[k][b] : m_fall[k][b]) ev[b] = 1'b1;
          end
        end else begin
          m_since[k][b] = -1;
        end
      end
      if (wr && address == 3'd3) m_ec[k] = m_ec[k] & ~writedata[3:0];
      m_ec[k] = m_ec[k] | ev;
      if (wr && address == 3'd6) m_cnt[k] = 0;
      if (ev != 4'h0 && m_cnt[k] < cnt_max(k)) m_cnt[k] = m_cnt[k] + 1;
      if (wr) begin
        case (address)
          3'd2: m_mask[k] = writedata[3:0];
          3'd4: m_rise[k] = writedata[3:0];
          3'd5: m_fall[k] = writedata[3:0];
          3'd7: m_thr[k]  = int'(writedata) & cnt_max(k);
          default: ;
        endcase
      end
    end
    in_hist[edge_idx % 16] = in_port;
    edge_idx++;
  endtask

  // Model advances on the same edges as the DUT, reset asynchronously.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else          m_step();
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (!done) begin
      chk("cyc_readdata_a", readdata_a, m_rd[0]);
      chk("cyc_readdata_b", readdata_b, m_rd[1]);
      chk("cyc_irq_a", {31'h0, irq_a}, {31'h0, |(m_ec[0] & m_mask[0])});
      chk("cyc_irq_b", {31'h0, irq_b}, {31'h0, |(m_ec[1] & m_mask[1])});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    $display("write addr=%0d data=0x%0h", a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] ea, input logic [31:0] eb,
                    input string nm);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    $display("read  addr=%0d a=0x%0h b=0x%0h (%s)", a, readdata_a, readdata_b, nm);
    chk({nm, "_a"}, readdata_a, ea);
    chk({nm, "_b"}, readdata_b, eb);
  endtask

  task automatic rd_reset_values(input string tag);
    rd(3'd0, 32'hF, 32'hF, {tag, "_data"});
    rd(3'd1, 32'hF, 32'hF, {tag, "_raw"});
    rd(3'd2, 32'h0, 32'h0, {tag, "_mask"});
    rd(3'd3, 32'h0, 32'h0, {tag, "_edge"});
    rd(3'd4, 32'h0, 32'h0, {tag, "_rise"});
    rd(3'd5, 32'hF, 32'hF, {tag, "_fall"});
    rd(3'd6, 32'h0, 32'h0, {tag, "_evcnt"});
    rd(3'd7, 32'd50000, 32'd3, {tag, "_thresh"});
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 4'hF;
    idle(3);
    chk("in_reset_readdata", readdata_a, 32'h0);
    chk("in_reset_irq", {31'h0, irq_a}, 32'h0);
    reset_n = 1'b1;

    // Reset state
    rd_reset_values("rst");
    idle(5);
    chk("post_rst_irq", {31'h0, irq_a}, 32'h0);
    rd(3'd3, 32'h0, 32'h0, "post_rst_edge");

    // Debounce: 3-cycle glitch rejected, 4+ cycle change accepted at edge 2+3
    wr(3'd7, 32'd3);
    idle(2);
    in_port = 4'hE; idle(3); in_port = 4'hF; idle(10);
    rd(3'd0, 32'hF, 32'hF, "glitch_data");
    rd(3'd6, 32'h0, 32'h0, "glitch_evcnt");
    address = 3'd0; chipselect = 1'b0; in_port = 4'hE;
    idle(6);
    chk("data_before_edge5", readdata_a, 32'hF);
    idle(1);
    chk("data_after_edge5", readdata_a, 32'hE);
    idle(2);
    rd(3'd3, 32'h1, 32'h1, "deb_edge");
    rd(3'd6, 32'h1, 32'h1, "deb_evcnt");
    chk("deb_irq_masked", {31'h0, irq_a}, 32'h0);
    in_port = 4'hF; idle(8);
    rd(3'd0, 32'hF, 32'hF, "deb_release_data");
    rd(3'd3, 32'h1, 32'h1, "deb_rise_ignored");
    wr(3'd3, 32'hF); wr(3'd6, 32'h0);
    rd(3'd3, 32'h0, 32'h0, "w1c_all");
    rd(3'd6, 32'h0, 32'h0, "evcnt_clear");

    // Edge modes: rise only on bit 1, bit 2 ignored
    wr(3'd4, 32'h2); wr(3'd5, 32'h0);
    in_port = 4'hD; idle(8); in_port = 4'hF; idle(8);
    rd(3'd3, 32'h2, 32'h2, "rise_only");
    in_port = 4'hB; idle(8); in_port = 4'hF; idle(8);
    rd(3'd3, 32'h2, 32'h2, "bit2_no_capture");
    rd(3'd6, 32'h1, 32'h1, "edge_mode_evcnt");

    // IRQ and W1C
    wr(3'd4, 32'h3);
    in_port = 4'hE; idle(8); in_port = 4'hF; idle(8);
    rd(3'd3, 32'h3, 32'h3, "edge_3");
    wr(3'd2, 32'h1);
    chk("irq_set", {31'h0, irq_a}, 32'h1);
    wr(3'd3, 32'h1);
    chk("irq_cleared", {31'h0, irq_a}, 32'h0);
    rd(3'd3, 32'h2, 32'h2, "w1c_bit0");
    in_port = 4'hD; idle(8);
    in_port = 4'hF; idle(5);
    wr(3'd3, 32'h2);                        // lands on the bit-1 rise flip edge
    rd(3'd3, 32'h2, 32'h2, "event_wins");
    wr(3'd3, 32'h2);
    rd(3'd3, 32'h0, 32'h0, "w1c_bit1");
    rd(3'd6, 32'h3, 32'h3, "irq_evcnt");

    // Counter with THRESH=0
    wr(3'd7, 32'h0); wr(3'd4, 32'hF); wr(3'd5, 32'hF); wr(3'd6, 32'h0); wr(3'd3, 32'hF);
    in_port = 4'hC; idle(4);                // two bits in one cycle: one count
    in_port = 4'hD; idle(4);
    in_port = 4'hF; idle(4);
    in_port = 4'hB; idle(4);
    rd(3'd6, 32'h4, 32'h3, "evcnt_4_sat");
    in_port = 4'hF; idle(4);
    rd(3'd6, 32'h5, 32'h3, "evcnt_5_sat");
    in_port = 4'hE; idle(2);
    wr(3'd6, 32'h0);                        // clear coincides with the flip edge
    rd(3'd6, 32'h1, 32'h1, "clear_plus_event");
    rd(3'd3, 32'h7, 32'h7, "counter_edge");

    // Reset mid-debounce with captures pending
    wr(3'd2, 32'hF); wr(3'd7, 32'd3);
    in_port = 4'hF; idle(2);
    chk("irq_before_reset", {31'h0, irq_a}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_irq_drop_a", {31'h0, irq_a}, 32'h0);
    chk("async_irq_drop_b", {31'h0, irq_b}, 32'h0);
    chk("async_readdata", readdata_a, 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(10);
    chk("post_midrst_irq", {31'h0, irq_a}, 32'h0);
    rd_reset_values("midrst");

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
